shiftreg_seq_ctrl: RTL and testbench
====================================

// Module: shiftreg_seq_ctrl
// PURPOSE
//  Sequencer for the 4-op shift/rotate datapath: accepts one command (data, op, count)
//  via valid/ready, applies op once per clock for count clocks, then holds the result
//  under valid/ready until consumed. Sits between a command master and result consumer;
//  implements the shift register internally, one shift step per cycle.
// PARAMETERS
//  WIDTH  4  data width (>=2)
//  CNT_W  3  width of shift count; max count = 2**CNT_W-1
// PORTS
//  clk        in   1      clock, all flops on posedge
//  rst_n      in   1      asynchronous reset, active-low
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept command
//  cmd_data   in   WIDTH  initial register value
//  cmd_op     in   2      00 shl-logical (LSB<-0), 01 shr-logical (MSB<-0), 10 rotl, 11 rotr
//  cmd_count  in   CNT_W  number of shift steps to apply
//  res_valid  out  1      result present
//  res_ready  in   1      consumer accepts result
//  res_data   out  WIDTH  shifted/rotated result
//  busy       out  1      1 in SHIFT or DONE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, cmd_ready=1, res_valid=0,
//    res_data=0, busy=0, internal reg=0, remaining count=0, latched op=00.
//  - States: IDLE -> SHIFT -> DONE -> IDLE. All outputs registered or decoded from state.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge: reg<=cmd_data, op/count latched;
//    next state SHIFT if cmd_count!=0, else DONE.
//  - SHIFT: cmd_ready=0. Each edge: reg<=f(op,reg), remaining<=remaining-1;
//    when remaining==1 at edge -> DONE. Exactly count steps applied.
//  - DONE: res_valid=1, res_data=reg (stable while res_valid&!res_ready).
//    On res_valid&res_ready at edge -> IDLE. No command accepted in DONE (cmd_ready=0).
//  - Latency: accept at edge E -> res_valid first high after edge E+count (count=0: E+1... i.e.
//    visible the cycle after acceptance; count=k: k+1 cycles after acceptance).
//  - Throughput: one command per count+2 cycles minimum (accept, k shifts, 1 result handshake).
//  - res_data = 0 outside DONE.
//  - Rotate by count>=WIDTH wraps naturally (rotl by WIDTH == identity); logical shift
//    by count>=WIDTH yields 0.
//  - cmd_op/cmd_data/cmd_count ignored unless handshake completes; changes during SHIFT
//    have no effect.
//  - rst_n low mid-SHIFT or mid-DONE: immediate return to reset values, result discarded.
// CONFIGURATION
//  SHIFTREG_SEQ_CTRL_ABORT_EN defined: adds input port abort (1 bit). abort=1 at an edge
//   while in SHIFT or DONE -> IDLE next cycle, res_valid never asserted for that command
//   (if in DONE with res_ready=1 same edge, abort wins, result not transferred);
//   abort ignored in IDLE. reg cleared to 0 on abort.
//  Not defined: no abort port; every accepted command produces exactly one result.
// TESTING
//  1 Reset: rst_n=0 mid-run -> cmd_ready=1, res_valid=0, res_data=0, busy=0 immediately.
//  2 data=4'b1011, op=00, count=1 -> res_data=4'b0110, res_valid 2 cycles after accept.
//  3 data=4'b1011, op=11, count=3 -> res_data=4'b0111 (rotr x3), res_valid 4 cycles after.
//  4 data=4'b1001, op=01, count=0 -> res_data=4'b1001 next cycle; op=10,count=4 -> 4'b1001.
//  5 Backpressure: res_ready=0 for 5 cycles -> res_data stable, cmd_ready=0; new cmd_valid
//    held high is accepted only on edge after res handshake.
//  6 ABORT_EN: abort during SHIFT (count=7, 3rd step) -> IDLE next cycle, no res_valid;
//    next command data=4'b0001,op=10,count=2 -> 4'b0100.

Source files
------------

// File: rtl/shiftreg_seq_ctrl.sv
// Command/result sequencer wrapping a 4-op shift/rotate register, one step per clock.
// Optional abort input enabled by defining SHIFTREG_SEQ_CTRL_ABORT_EN.
module shiftreg_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       op_q, op_d;

    function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        unique case (op)
            2'b00:   r = {v[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, v[WIDTH-1:1]};
            2'b10:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = {v[0], v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    shreg_d     = cmd_data;
                    op_d        = cmd_op;
                    remaining_d = cmd_count;
                    state_d     = (cmd_count != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                shreg_d     = shift_step(op_q, shreg_q);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
        // Abort overrides everything, including a same-edge result handshake.
        if (abort && state_q != StIdle) begin
            state_d     = StIdle;
            shreg_d     = '0;
            remaining_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            remaining_q <= '0;
            op_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
        end
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        res_valid = (state_q == StDone);
        busy      = (state_q == StShift) || (state_q == StDone);
        res_data  = (state_q == StDone) ? shreg_q : '0;
    end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Randomized self-checking bench for shiftreg_seq_ctrl against an arithmetic reference model.
// Abort scenarios are exercised when SHIFTREG_SEQ_CTRL_ABORT_EN is defined.
module tb_shiftreg_seq_ctrl;

    localparam int W = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          busy;
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
    logic          abort;
`endif

    int checks = 0;
    int errors = 0;

    shiftreg_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-operation model: apply op k times as one arithmetic shift/rotate.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] op,
                                           input int k);
        int v;
        int s;
        int mask;
        int r;
        v    = int'(d);
        mask = (1 << W) - 1;
        s    = k % W;
        case (op)
            2'b00:   r = (k >= W) ? 0 : ((v << k) & mask);
            2'b01:   r = (k >= W) ? 0 : (v >> k);
            2'b10:   r = ((v << s) | (v >> (W - s))) & mask;
            default: r = ((v >> s) | (v << (W - s))) & mask;
        endcase
        return r[W-1:0];
    endfunction

    // Issues one command, waits for the result, optionally stalls res_ready, then consumes it.
    // lat counts negedges from the accept edge until res_valid is first seen.
    task automatic do_cmd(input logic [W-1:0] d, input logic [1:0] op, input logic [CW-1:0] k,
                          input int stall, output logic [W-1:0] res, output int lat,
                          output bit ok);
        int w;
        ok = 1'b1;
        res = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_op    = op;
        cmd_count = k;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 64) begin
            cmd_data  = W'($urandom);
            cmd_op    = 2'($urandom);
            cmd_count = CW'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!res_valid) ok = 1'b0;
        res = res_data;
        repeat (stall) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_op    = '0;
        cmd_count = '0;
        res_ready = 1'b0;
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        #3;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%h busy=%b want 1 0 0 0",
                     cmd_ready, res_valid, res_data, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [W-1:0] dv[4] = '{4'b1011, 4'b1011, 4'b1001, 4'b1001};
        logic [1:0]   ov[4] = '{2'b00, 2'b11, 2'b01, 2'b10};
        logic [CW-1:0] kv[4] = '{3'd1, 3'd3, 3'd0, 3'd4};
        logic [W-1:0] ev[4] = '{4'b0110, 4'b0111, 4'b1001, 4'b1001};
        logic [W-1:0] res;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_cmd(dv[i], ov[i], kv[i], 0, res, lat, ok);
            checks++;
            if (!ok || res !== ev[i] || lat != int'(kv[i]) + 1) begin
                errors++;
                $display("FAIL directed_%0d: got data=%b lat=%0d ok=%0d want data=%b lat=%0d",
                         i, res, lat, ok, ev[i], int'(kv[i]) + 1);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] d;
        logic [1:0] op;
        logic [CW-1:0] k;
        logic [W-1:0] res;
        int lat;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            d  = W'($urandom);
            op = 2'($urandom);
            k  = CW'($urandom);
            do_cmd(d, op, k, $urandom_range(0, 3), res, lat, ok);
            checks++;
            if (!ok || res !== model(d, op, int'(k)) || lat != int'(k) + 1) begin
                errors++;
                $display("FAIL random_%0d: d=%b op=%0d k=%0d got data=%b lat=%0d want %b lat=%0d",
                         i, d, op, k, res, lat, model(d, op, int'(k)), int'(k) + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] d;
        logic [W-1:0] nd;
        int w;
        d  = W'($urandom);
        nd = W'($urandom);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_op    = 2'b10;
        cmd_count = 3'd2;
        @(negedge clk);
        // Second command held on the bus for the whole result stall.
        cmd_data  = nd;
        cmd_op    = 2'b01;
        cmd_count = 3'd1;
        w = 0;
        while (!res_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== model(d, 2'b10, 2) || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: got vld=%b data=%b rdy=%b want 1 %b 0",
                         i, res_valid, res_data, cmd_ready, model(d, 2'b10, 2));
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b busy=%b vld=%b want 1 0 0",
                     cmd_ready, busy, res_valid);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept: got busy=%b rdy=%b want 1 0", busy, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== model(nd, 2'b01, 1)) begin
            errors++;
            $display("FAIL backpressure_second: got vld=%b data=%b want 1 %b",
                     res_valid, res_data, model(nd, 2'b01, 1));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] dq[$];
        logic [1:0] oq[$];
        int kq[$];
        int accq[$];
        int cyc;
        int nacc;
        int nres;
        int last_acc;
        int last_k;
        logic [W-1:0] d;
        logic [1:0] op;
        int k;
        bit acc;
        cyc = 0;
        nacc = 0;
        nres = 0;
        last_acc = -1;
        last_k = 0;
        @(negedge clk);
        d = W'($urandom);
        op = 2'($urandom);
        k = $urandom_range(0, 7);
        cmd_valid = 1'b1;
        cmd_data = d;
        cmd_op = op;
        cmd_count = CW'(k);
        res_ready = 1'b1;
        while (nres < 8 && cyc < 200) begin
            acc = 1'b0;
            if (res_valid) begin
                checks++;
                if (res_data !== model(dq[0], oq[0], kq[0]) || cyc - accq[0] != kq[0] + 1) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got data=%b lat=%0d want %b lat=%0d", nres,
                             res_data, cyc - accq[0], model(dq[0], oq[0], kq[0]), kq[0] + 1);
                end
                void'(dq.pop_front());
                void'(oq.pop_front());
                void'(kq.pop_front());
                void'(accq.pop_front());
                nres++;
            end
            if (cmd_valid && cmd_ready) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != last_k + 2) begin
                        errors++;
                        $display("FAIL b2b_interval_%0d: got %0d want %0d", nacc,
                                 cyc - last_acc, last_k + 2);
                    end
                end
                dq.push_back(d);
                oq.push_back(op);
                kq.push_back(k);
                accq.push_back(cyc);
                last_acc = cyc;
                last_k = k;
                nacc++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (nacc < 8) begin
                    d = W'($urandom);
                    op = 2'($urandom);
                    k = $urandom_range(0, 7);
                    cmd_data = d;
                    cmd_op = op;
                    cmd_count = CW'(k);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (nres != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 8", nres);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 4'b1111;
        cmd_op = 2'b00;
        cmd_count = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shift: got rdy=%b vld=%b data=%h busy=%b want 1 0 0 0",
                     cmd_ready, res_valid, res_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_data = 4'b1010;
        cmd_count = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 4'b1010) begin
            errors++;
            $display("FAIL done_before_reset: got vld=%b data=%b want 1 1010", res_valid, res_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: got rdy=%b vld=%b data=%h busy=%b want 1 0 0 0",
                     cmd_ready, res_valid, res_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
    task automatic test_abort;
        logic [W-1:0] res;
        int lat;
        bit ok;
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 4'b0110;
        cmd_op = 2'b10;
        cmd_count = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_shift: got busy=%b rdy=%b vld=%b want 0 1 0",
                     busy, cmd_ready, res_valid);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_result: got res_valid=1 want 0");
        end
        do_cmd(4'b0001, 2'b10, 3'd2, 0, res, lat, ok);
        checks++;
        if (!ok || res !== 4'b0100) begin
            errors++;
            $display("FAIL abort_next_cmd: got %b ok=%0d want 0100", res, ok);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 4'b0011;
        cmd_count = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: got busy=%b vld=%b want 0 0", busy, res_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SHIFTREG_SEQ_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
